cdb_arbiter: RTL

//  Common data bus for the Tomasulo core: NUM_SRC producers (ALU, branch ALU, LS buffer) each have a result FIFO.

---
 rtl/cdb_arbiter_pkg.sv | 33 +++
 rtl/cdb_src_fifo.sv | 97 +++++++++
 rtl/cdb_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared widths, the free-tag value, CDB source indices and small helper
//   functions for the common data bus arbiter and its per-source FIFOs.
//   Optional feature macro used by the files importing this package:
//   CDB_FLUSH_EN (adds the flush port and flush logic).
package cdb_arbiter_pkg;

  localparam int TAG_WIDTH    = 5;
  localparam int DATA_WIDTH   = 32;
  localparam int ALU_RS_WIDTH = 2;
  localparam int CDB_NUM_SRC  = 3;

  // All-ones tag marks "no result on the bus".
  localparam logic [TAG_WIDTH-1:0] TAG_FREE = '1;

  // Fixed producer channel assignment on the bus.
  typedef enum logic [1:0] {
    CDB_SRC_ALU = 2'd0,
    CDB_SRC_BR  = 2'd1,
    CDB_SRC_LS  = 2'd2
  } cdb_src_e;

  // Occupancy counters need one extra bit so "full" (== depth) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Channel visited at step 'offset' of a round-robin scan that starts after 'ptr'.
  function automatic int rr_index(input int ptr, input int offset, input int n);
    return (ptr + offset) % n;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo
//   One producer's result queue in front of the common data bus.
//   Circular buffer of DEPTH entries with same-cycle read and write support.
//   Optional macro: CDB_FLUSH_EN adds the clr input, which empties the queue
//   and overrides any read or write in the same cycle.
// Ports
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   clr        discard all entries (CDB_FLUSH_EN only)
//   wr_en      write wr_data at the tail (ignored when full)
//   wr_data    entry to store
//   rd_en      drop the head entry (ignored when empty)
//   head       oldest entry, valid when !empty
//   empty      no entries stored
//   full       count == DEPTH
//   count      number of stored entries
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef CDB_FLUSH_EN
  input  logic                         clr,
`endif
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic                         full,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointers are exactly log2(DEPTH) bits, so incrementing wraps for free.
  // A simultaneous read and write moves both pointers and leaves count alone.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
`ifdef CDB_FLUSH_EN
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Common data bus of the Tomasulo core. Each producer (ALU, branch ALU,
//   LS buffer) pushes results into its own FIFO; every cycle a round-robin
//   arbiter picks one result, broadcasts it on the registered CDB outputs and
//   sends a one-hot finish pulse plus the RS index back to the winner.
//   A result offered to an empty channel that wins in the same cycle bypasses
//   its FIFO, giving one-cycle latency from push to broadcast.
//   Optional macro: CDB_FLUSH_EN adds the flush input, which empties every
//   FIFO, drops that cycle's pushes and idles the bus (rr_ptr kept).
// Ports
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   src_valid   per-channel result offer
//   src_tag     packed tags, channel i at [i*TAG_W +: TAG_W]
//   src_data    packed data, channel i at [i*DATA_W +: DATA_W]
//   src_rs      packed RS indices, channel i at [i*RS_W +: RS_W]
//   src_ready   channel FIFO not full (combinational)
//   flush       discard all pending results (CDB_FLUSH_EN only)
//   cdb_valid   broadcast valid
//   cdb_tag     broadcast tag, free tag when idle
//   cdb_data    broadcast data, zero when idle
//   fin         one-hot finish to the winning producer
//   fin_rs      RS index of the broadcast result
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = TAG_WIDTH,
  parameter int DATA_W  = DATA_WIDTH,
  parameter int RS_W    = ALU_RS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*RS_W-1:0]   src_rs,
  output logic [NUM_SRC-1:0]        src_ready,
`ifdef CDB_FLUSH_EN
  input  logic                      flush,
`endif
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [NUM_SRC-1:0]        fin,
  output logic [RS_W-1:0]           fin_rs
);

  localparam int ENTRY_W   = TAG_W + DATA_W + RS_W;
  localparam int SRC_IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W     = cnt_width(DEPTH);
  localparam logic [TAG_W-1:0] TAG_IDLE = TAG_W'(TAG_FREE);

  logic [ENTRY_W-1:0]   src_entry  [NUM_SRC];
  logic [ENTRY_W-1:0]   fifo_head  [NUM_SRC];
  logic [CNT_W-1:0]     fifo_count [NUM_SRC];
  logic [NUM_SRC-1:0]   fifo_empty;
  logic [NUM_SRC-1:0]   fifo_full;
  logic [NUM_SRC-1:0]   fifo_wr;
  logic [NUM_SRC-1:0]   fifo_rd;
  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   cand;
  logic [NUM_SRC-1:0]   grant_oh;
  logic                 grant;
  logic                 take;
  logic [SRC_IDX_W-1:0] winner;
  logic [SRC_IDX_W-1:0] scan_idx;
  logic [ENTRY_W-1:0]   win_entry;

  logic                 cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]     cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0]    cdb_data_q,  cdb_data_d;
  logic [NUM_SRC-1:0]   fin_q,       fin_d;
  logic [RS_W-1:0]      fin_rs_q,    fin_rs_d;
  logic [SRC_IDX_W-1:0] rr_ptr_q,    rr_ptr_d;

  // Per-channel FIFO plus the ready/push/candidate terms. Entries are packed
  // as {tag, data, rs}. A channel competes either with its FIFO head or,
  // when the FIFO is empty, with the result being pushed right now.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src_entry[g] = {src_tag[g*TAG_W +: TAG_W],
                           src_data[g*DATA_W +: DATA_W],
                           src_rs[g*RS_W +: RS_W]};
    assign src_ready[g] = (fifo_count[g] < CNT_W'(DEPTH));
    assign push[g]      = src_valid[g] && src_ready[g];
    assign cand[g]      = !fifo_empty[g] || push[g];

    cdb_src_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
`ifdef CDB_FLUSH_EN
      .clr     (flush),
`endif
      .wr_en   (fifo_wr[g]),
      .wr_data (src_entry[g]),
      .rd_en   (fifo_rd[g]),
      .head    (fifo_head[g]),
      .empty   (fifo_empty[g]),
      .full    (fifo_full[g]),
      .count   (fifo_count[g])
    );

    a_full_matches_count: assert property (@(posedge clk) disable iff (rst)
      fifo_full[g] == (fifo_count[g] == CNT_W'(DEPTH)));
  end

  // Round-robin scan starting one past the last winner.
  always_comb begin
    grant    = 1'b0;
    winner   = rr_ptr_q;
    scan_idx = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      scan_idx = SRC_IDX_W'(rr_index(int'(rr_ptr_q), k, NUM_SRC));
      if (!grant && cand[scan_idx]) begin
        grant  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // A winner with an empty FIFO is served straight from its input, so its
  // push must not also land in the FIFO.
  always_comb begin
    grant_oh = '0;
    fifo_rd  = '0;
    fifo_wr  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      grant_oh[i] = grant && (winner == SRC_IDX_W'(i));
      fifo_rd[i]  = grant_oh[i] && !fifo_empty[i];
      fifo_wr[i]  = push[i] && !(grant_oh[i] && fifo_empty[i]);
    end
  end

  assign win_entry = fifo_empty[winner] ? src_entry[winner] : fifo_head[winner];

  // Flush beats a grant: the bus idles and the pointer stays put.
`ifdef CDB_FLUSH_EN
  assign take = grant && !flush;
`else
  assign take = grant;
`endif

  // Output register defaults to idle every cycle so a broadcast is a single
  // cycle pulse.
  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_tag_d   = TAG_IDLE;
    cdb_data_d  = '0;
    fin_d       = '0;
    fin_rs_d    = '0;
    rr_ptr_d    = rr_ptr_q;
    if (take) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = win_entry[ENTRY_W-1 -: TAG_W];
      cdb_data_d  = win_entry[RS_W +: DATA_W];
      fin_d       = grant_oh;
      fin_rs_d    = win_entry[RS_W-1:0];
      rr_ptr_d    = winner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= TAG_IDLE;
      cdb_data_q  <= '0;
      fin_q       <= '0;
      fin_rs_q    <= '0;
      rr_ptr_q    <= SRC_IDX_W'(NUM_SRC - 1);
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      fin_q       <= fin_d;
      fin_rs_q    <= fin_rs_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign fin       = fin_q;
  assign fin_rs    = fin_rs_q;

endmodule
